// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared SPI constants and FSM state encoding for master/slave.
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

  localparam int SPI_BITS      = 8;
  localparam int SPI_BIT_W     = $clog2(SPI_BITS);
  localparam bit SPI_LSB_FIRST = 1'b1;
  localparam bit SPI_CPOL      = 1'b0;
  localparam bit SPI_CPHA      = 1'b0;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_LOW   = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_SETUP = ST_SETUP,
    S_HIGH  = ST_HIGH,
    S_LOW   = ST_LOW,
    S_HOLD  = ST_HOLD,
    S_GAP   = ST_GAP
  } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : spi_phase_timer
// Purpose  : Reloadable down-counter; tc_o marks the last cycle of a phase.
// Revision : 1.0 - initial release
// ============================================================================
module spi_phase_timer #(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = $clog2(CLK_DIV)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] C_RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= C_RELOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign tc_o = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/spi_master_driver.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_driver
// Purpose  : Single-byte SPI master, mode 0, LSB first, active-low CS.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_driver
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = $clog2(CLK_DIV)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [SPI_BITS-1:0] data_in_bi,
  output logic                ready_o,
  output logic                done_o,
  output logic [SPI_BITS-1:0] data_out_bo,
  input  logic                spi_miso_i,
  output logic                spi_mosi_o,
  output logic                spi_sclk_o,
  output logic                spi_cs_o
);

  generate
    if (CLK_DIV < 2) begin : g_bad_div
      $error("spi_master_driver: CLK_DIV must be 2 or more");
    end
  endgenerate

  spi_state_e             r_state,   w_state;
  logic [SPI_BIT_W-1:0]   r_bit_cnt, w_bit_cnt;
  logic [SPI_BITS-1:0]    r_tx_sr,   w_tx_sr;
  logic [SPI_BITS-1:0]    r_rx_sr,   w_rx_sr;
  logic [SPI_BITS-1:0]    r_dout,    w_dout;
  logic                   r_cs,      w_cs;
  logic                   r_sclk,    w_sclk;
  logic                   r_mosi,    w_mosi;
  logic                   r_ready,   w_ready;
  logic                   r_done,    w_done;
  logic                   w_load;
  logic                   w_tc;

  spi_phase_timer #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (w_load),
    .tc_o   (w_tc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_tx_sr   <= '0;
      r_rx_sr   <= '0;
      r_dout    <= '0;
      r_cs      <= 1'b1;
      r_sclk    <= SPI_CPOL;
      r_mosi    <= 1'b0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_bit_cnt <= w_bit_cnt;
      r_tx_sr   <= w_tx_sr;
      r_rx_sr   <= w_rx_sr;
      r_dout    <= w_dout;
      r_cs      <= w_cs;
      r_sclk    <= w_sclk;
      r_mosi    <= w_mosi;
      r_ready   <= w_ready;
      r_done    <= w_done;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_bit_cnt = r_bit_cnt;
    w_tx_sr   = r_tx_sr;
    w_rx_sr   = r_rx_sr;
    w_dout    = r_dout;
    w_cs      = r_cs;
    w_sclk    = r_sclk;
    w_mosi    = r_mosi;
    w_ready   = r_ready;
    w_done    = 1'b0;
    w_load    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_tx_sr   = data_in_bi;
          w_mosi    = data_in_bi[0];
          w_cs      = 1'b0;
          w_ready   = 1'b0;
          w_bit_cnt = '0;
          w_load    = 1'b1;
          w_state   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_tc) begin
          w_sclk  = 1'b1;
          w_load  = 1'b1;
          w_state = S_HIGH;
        end
      end
      S_HIGH: begin
        if (w_tc) begin
          w_rx_sr = {spi_miso_i, r_rx_sr[SPI_BITS-1:1]};
          w_sclk  = 1'b0;
          w_load  = 1'b1;
          if (r_bit_cnt == SPI_BIT_W'(SPI_BITS - 1)) begin
            w_state = S_HOLD;
          end else begin
            // Next MOSI bit is launched on the falling edge, ahead of the next rise
            w_tx_sr   = r_tx_sr >> 1;
            w_mosi    = r_tx_sr[1];
            w_bit_cnt = r_bit_cnt + 1'b1;
            w_state   = S_LOW;
          end
        end
      end
      S_LOW: begin
        if (w_tc) begin
          w_sclk  = 1'b1;
          w_load  = 1'b1;
          w_state = S_HIGH;
        end
      end
      S_HOLD: begin
        if (w_tc) begin
          w_cs    = 1'b1;
          w_mosi  = 1'b0;
          w_dout  = r_rx_sr;
          w_done  = 1'b1;
          w_load  = 1'b1;
          w_state = S_GAP;
        end
      end
      S_GAP: begin
        if (w_tc) begin
          w_ready = 1'b1;
          w_state = S_IDLE;
        end
      end
      default: begin
        w_cs    = 1'b1;
        w_sclk  = SPI_CPOL;
        w_mosi  = 1'b0;
        w_ready = 1'b1;
        w_state = S_IDLE;
      end
    endcase
  end

  assign ready_o     = r_ready;
  assign done_o      = r_done;
  assign data_out_bo = r_dout;
  assign spi_mosi_o  = r_mosi;
  assign spi_sclk_o  = r_sclk;
  assign spi_cs_o    = r_cs;

endmodule
`default_nettype wire
